// File: rtl/countdown_timer.sv
// countdown_timer: six-digit BCD hh:mm:ss countdown from a loaded preset.
// Commands are resolved by fixed priority each cycle:
//   clear > load > pause > start > tick
// A tick decrements by one second through a BCD borrow chain. Reaching
// 00:00:00 returns to IDLE and pulses o_done for one cycle.
module countdown_timer (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic [3:0] i_hour_h,
    input  logic [3:0] i_hour_l,
    input  logic [3:0] i_minut_h,
    input  logic [3:0] i_minut_l,
    input  logic [3:0] i_second_h,
    input  logic [3:0] i_second_l,
    output logic [3:0] o_hour_h,
    output logic [3:0] o_hour_l,
    output logic [3:0] o_minut_h,
    output logic [3:0] o_minut_l,
    output logic [3:0] o_second_h,
    output logic [3:0] o_second_l,
    output logic       o_running,
    output logic       o_done,
    output logic       o_load_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] hour_h_q, hour_h_d, hour_l_q, hour_l_d;
    logic [3:0] minut_h_q, minut_h_d, minut_l_q, minut_l_d;
    logic [3:0] second_h_q, second_h_d, second_l_q, second_l_d;
    logic       done_q, done_d;
    logic       load_err_q, load_err_d;

    logic       preset_ok;
    logic       value_zero;
    logic       value_one;
    logic [3:0] dec_hour_h, dec_hour_l, dec_minut_h, dec_minut_l;
    logic [3:0] dec_second_h, dec_second_l;
    logic       b_sl, b_sh, b_ml, b_mh, b_hl;

    // Preset legality and zero / one-second detection on the current value
    always_comb begin
        preset_ok = (i_hour_l <= 4'd9) && (i_minut_l <= 4'd9) &&
                    (i_second_l <= 4'd9) && (i_minut_h <= 4'd5) &&
                    (i_second_h <= 4'd5) && (i_hour_h <= 4'd2) &&
                    !((i_hour_h == 4'd2) && (i_hour_l > 4'd3));
        value_zero = (hour_h_q == 4'd0) && (hour_l_q == 4'd0) &&
                     (minut_h_q == 4'd0) && (minut_l_q == 4'd0) &&
                     (second_h_q == 4'd0) && (second_l_q == 4'd0);
        value_one  = (hour_h_q == 4'd0) && (hour_l_q == 4'd0) &&
                     (minut_h_q == 4'd0) && (minut_l_q == 4'd0) &&
                     (second_h_q == 4'd0) && (second_l_q == 4'd1);
    end

    // One-second BCD decrement with the borrow rippling from seconds to hours
    always_comb begin
        b_sl         = (second_l_q == 4'd0);
        dec_second_l = b_sl ? 4'd9 : second_l_q - 4'd1;

        b_sh         = b_sl && (second_h_q == 4'd0);
        dec_second_h = !b_sl ? second_h_q :
                       (second_h_q == 4'd0) ? 4'd5 : second_h_q - 4'd1;

        b_ml         = b_sh && (minut_l_q == 4'd0);
        dec_minut_l  = !b_sh ? minut_l_q :
                       (minut_l_q == 4'd0) ? 4'd9 : minut_l_q - 4'd1;

        b_mh         = b_ml && (minut_h_q == 4'd0);
        dec_minut_h  = !b_ml ? minut_h_q :
                       (minut_h_q == 4'd0) ? 4'd5 : minut_h_q - 4'd1;

        b_hl         = b_mh && (hour_l_q == 4'd0);
        dec_hour_l   = !b_mh ? hour_l_q :
                       (hour_l_q == 4'd0) ? 4'd9 : hour_l_q - 4'd1;

        // Never borrows out of hour_h: RUN leaves at zero before that can happen
        dec_hour_h   = b_hl ? hour_h_q - 4'd1 : hour_h_q;
    end

    // Command resolution and next-state / next-value selection
    always_comb begin
        state_d    = state_q;
        hour_h_d   = hour_h_q;
        hour_l_d   = hour_l_q;
        minut_h_d  = minut_h_q;
        minut_l_d  = minut_l_q;
        second_h_d = second_h_q;
        second_l_d = second_l_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (i_clear) begin
            state_d    = ST_IDLE;
            hour_h_d   = '0;
            hour_l_d   = '0;
            minut_h_d  = '0;
            minut_l_d  = '0;
            second_h_d = '0;
            second_l_d = '0;
        end else if (i_load) begin
            // A load consumes the cycle even in RUN, where it is otherwise ignored
            if (state_q != ST_RUN) begin
                if (preset_ok) begin
                    hour_h_d   = i_hour_h;
                    hour_l_d   = i_hour_l;
                    minut_h_d  = i_minut_h;
                    minut_l_d  = i_minut_l;
                    second_h_d = i_second_h;
                    second_l_d = i_second_l;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (i_pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (i_start) begin
            if ((state_q != ST_RUN) && !value_zero) begin
                state_d = ST_RUN;
            end
        end else if (i_tick && (state_q == ST_RUN)) begin
            hour_h_d   = dec_hour_h;
            hour_l_d   = dec_hour_l;
            minut_h_d  = dec_minut_h;
            minut_l_d  = dec_minut_l;
            second_h_d = dec_second_h;
            second_l_d = dec_second_l;
            if (value_one) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State, digit and pulse registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            hour_h_q   <= '0;
            hour_l_q   <= '0;
            minut_h_q  <= '0;
            minut_l_q  <= '0;
            second_h_q <= '0;
            second_l_q <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_h_q   <= hour_h_d;
            hour_l_q   <= hour_l_d;
            minut_h_q  <= minut_h_d;
            minut_l_q  <= minut_l_d;
            second_h_q <= second_h_d;
            second_l_q <= second_l_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign o_hour_h   = hour_h_q;
    assign o_hour_l   = hour_l_q;
    assign o_minut_h  = minut_h_q;
    assign o_minut_l  = minut_l_q;
    assign o_second_h = second_h_q;
    assign o_second_l = second_l_q;
    assign o_running  = (state_q == ST_RUN);
    assign o_done     = done_q;
    assign o_load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer.
// The reference model keeps the count as a plain number of seconds and
// converts it to BCD digits only for comparison against the DUT outputs.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, clr, ld, st, ps;
    logic [3:0] p_hh, p_hl, p_mh, p_ml, p_sh, p_sl;
    logic [3:0] o_hh, o_hl, o_mh, o_ml, o_sh, o_sl;
    logic       running, done, load_err;
    logic [23:0] dig;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    int m_secs;
    int m_mode;
    bit m_done;
    bit m_err;

    always #5 clk = ~clk;

    assign dig = {o_hh, o_hl, o_mh, o_ml, o_sh, o_sl};

    countdown_timer dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_tick     (tick),
        .i_clear    (clr),
        .i_load     (ld),
        .i_start    (st),
        .i_pause    (ps),
        .i_hour_h   (p_hh),
        .i_hour_l   (p_hl),
        .i_minut_h  (p_mh),
        .i_minut_l  (p_ml),
        .i_second_h (p_sh),
        .i_second_l (p_sl),
        .o_hour_h   (o_hh),
        .o_hour_l   (o_hl),
        .o_minut_h  (o_mh),
        .o_minut_l  (o_ml),
        .o_second_h (o_sh),
        .o_second_l (o_sl),
        .o_running  (running),
        .o_done     (done),
        .o_load_err (load_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] secs_to_bcd(input int s);
        int h, m, sc;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic bit preset_valid();
        int h, m, s;
        if (p_hl > 9 || p_ml > 9 || p_sl > 9 || p_hh > 9 || p_mh > 9 || p_sh > 9) return 1'b0;
        h = int'(p_hh) * 10 + int'(p_hl);
        m = int'(p_mh) * 10 + int'(p_ml);
        s = int'(p_sh) * 10 + int'(p_sl);
        return (h < 24) && (m < 60) && (s < 60);
    endfunction

    function automatic int preset_secs();
        return (int'(p_hh) * 10 + int'(p_hl)) * 3600 +
               (int'(p_mh) * 10 + int'(p_ml)) * 60 +
               (int'(p_sh) * 10 + int'(p_sl));
    endfunction

    // Apply one clock cycle's commands to the reference model
    task automatic model_step();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (clr) begin
            m_secs = 0;
            m_mode = M_IDLE;
        end else if (ld) begin
            if (m_mode != M_RUN) begin
                if (preset_valid()) m_secs = preset_secs();
                else                m_err  = 1'b1;
            end
        end else if (ps && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
        end else if (st) begin
            if (m_mode != M_RUN && m_secs != 0) m_mode = M_RUN;
        end else if (tick && m_mode == M_RUN) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_mode = M_IDLE;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        check("digits",   32'(dig),      32'(secs_to_bcd(m_secs)));
        check("running",  32'(running),  32'(m_mode == M_RUN));
        check("done",     32'(done),     32'(m_done));
        check("load_err", 32'(load_err), 32'(m_err));
    endtask

    // Drive one cycle of commands, advance the clock, update and compare
    task automatic cyc(input bit c, input bit l, input bit p, input bit s, input bit t);
        clr  = c;
        ld   = l;
        ps   = p;
        st   = s;
        tick = t;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_preset(input logic [23:0] v);
        {p_hh, p_hl, p_mh, p_ml, p_sh, p_sl} = v;
    endtask

    initial begin
        rst_n = 1'b0;
        {tick, clr, ld, st, ps} = '0;
        set_preset('0);
        m_secs = 0;
        m_mode = M_IDLE;
        m_done = 1'b0;
        m_err  = 1'b0;

        @(posedge clk);
        #1;
        check("reset_digits", 32'(dig), 32'h0);
        check("reset_flags",  32'({running, done, load_err}), 32'h0);
        rst_n = 1'b1;

        // 00:01:00 counts down to zero with a single done pulse
        set_preset(24'h000100);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check("first_tick", 32'(dig), 32'h000059);
        for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 1);
        check("expiry_done", 32'({dig, running, done}), 32'h000000_1);
        cyc(0, 0, 0, 0, 1);
        check("post_expiry", 32'({dig, running, done}), 32'h0);

        // Hour borrows
        set_preset(24'h100000);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check("borrow_10h", 32'(dig), 32'h095959);
        cyc(0, 0, 1, 0, 0);
        set_preset(24'h200000);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check("borrow_20h", 32'(dig), 32'h195959);
        cyc(0, 0, 1, 0, 0);

        // Preset legality boundaries
        set_preset(24'h235959);
        cyc(0, 1, 0, 0, 0);
        check("load_max", 32'({dig, load_err}), {24'h235959, 1'b0});
        set_preset(24'h240000);
        cyc(0, 1, 0, 0, 0);
        check("load_24h", 32'({dig, load_err}), {24'h235959, 1'b1});
        set_preset(24'h126000);
        cyc(0, 1, 0, 0, 0);
        set_preset(24'h0A0000);
        cyc(0, 1, 0, 0, 0);
        check("load_hex", 32'({dig, load_err}), {24'h235959, 1'b1});
        cyc(0, 0, 0, 0, 0);

        // Pause freezes, start+pause in RUN pauses, start resumes
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
        check("paused_frozen", 32'(dig), 32'h235956);
        cyc(0, 0, 1, 1, 0);
        check("start_in_pause", 32'(running), 32'h1);
        cyc(0, 0, 1, 1, 1);
        check("start_pause_run", 32'({dig, running}), {24'h235956, 1'b0});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        check("resume", 32'(dig), 32'h235955);

        // Start at zero is ignored; load during RUN is ignored
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("start_zero", 32'({running, done}), 32'h0);
        set_preset(24'h000005);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        set_preset(24'h000009);
        cyc(0, 1, 0, 0, 1);
        check("load_in_run", 32'({dig, running, load_err}), {24'h000005, 2'b10});

        // Clear together with tick in RUN
        cyc(1, 0, 0, 0, 1);
        check("clear_tick", 32'({dig, running, done}), 32'h0);

        // Asynchronous reset mid-count
        set_preset(24'h053017);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({dig, running, done, load_err}), 32'h0);
        m_secs = 0;
        m_mode = M_IDLE;
        m_done = 1'b0;
        m_err  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized commands against the reference model
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0: set_preset(24'($urandom));
                1: set_preset({16'h0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
                2: set_preset({4'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
                               4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
                default: set_preset({12'h0, 4'($urandom_range(0, 2)),
                                     4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
            endcase
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
